// File: rtl/fgh_truth_scanner.sv
// Truth-table scanner: sweeps w over minterms 0..15, captures f/g/h after a
// settle delay, and compares the captured tables against expected constants.
module fgh_truth_scanner #(
    parameter int unsigned SETTLE = 1,
    parameter logic [15:0] EXP_F  = 16'h4CC8,
    parameter logic [15:0] EXP_G  = 16'h440C,
    parameter logic [15:0] EXP_H  = 16'hC08B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f,
    input  logic        g,
    input  logic        h,
    output logic [3:0]  w,
    output logic [15:0] tt_f,
    output logic [15:0] tt_g,
    output logic [15:0] tt_h,
    output logic        busy,
    output logic        done,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  w_n;
    logic [15:0] tt_f_n, tt_g_n, tt_h_n;
    logic        pass_n, busy_n, done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            w     <= '0;
            cnt   <= '0;
            tt_f  <= '0;
            tt_g  <= '0;
            tt_h  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            state <= state_n;
            w     <= w_n;
            cnt   <= cnt_n;
            tt_f  <= tt_f_n;
            tt_g  <= tt_g_n;
            tt_h  <= tt_h_n;
            busy  <= busy_n;
            done  <= done_n;
            pass  <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        w_n     = w;
        cnt_n   = cnt;
        tt_f_n  = tt_f;
        tt_g_n  = tt_g;
        tt_h_n  = tt_h;
        pass_n  = pass;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    w_n     = '0;
                    cnt_n   = SETTLE_M1;
                    tt_f_n  = '0;
                    tt_g_n  = '0;
                    tt_h_n  = '0;
                    pass_n  = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    pass_n  = 1'b0;
                end else if (cnt == 4'd0) begin
                    tt_f_n[w] = f;
                    tt_g_n[w] = g;
                    tt_h_n[w] = h;
                    if (w == 4'd15) begin
                        state_n = DONE;
                        // compare the post-write tables so pass is valid alongside done
                        pass_n  = (tt_f_n == EXP_F) && (tt_g_n == EXP_G) && (tt_h_n == EXP_H);
                    end else begin
                        w_n   = w + 4'd1;
                        cnt_n = SETTLE_M1;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                pass_n  = (tt_f == EXP_F) && (tt_g == EXP_G) && (tt_h == EXP_H);
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_fgh_truth_scanner.sv
// Directed bench for fgh_truth_scanner: two instances (SETTLE=1 and SETTLE=3)
// driving a behavioural function block built from the expected truth tables.
module tb_fgh_truth_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic        abort1 = 1'b0, abort3 = 1'b0;
    logic        stuck_f = 1'b0;
    logic        sel = 1'b0;

    logic [15:0] exp_f_v = 16'h4CC8;
    logic [15:0] exp_g_v = 16'h440C;
    logic [15:0] exp_h_v = 16'hC08B;

    logic [3:0]  w1, w3;
    logic [15:0] ttf1, ttg1, tth1, ttf3, ttg3, tth3;
    logic        busy1, done1, pass1, busy3, done3, pass3;
    logic        f1, g1, h1, f3, g3, h3;

    logic [3:0]  o_w;
    logic [15:0] o_tt_f, o_tt_g, o_tt_h;
    logic        o_busy, o_done, o_pass;

    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    // Reference function block: each output is its expected table indexed by w
    always_comb begin
        f1 = stuck_f | exp_f_v[w1];
        g1 = exp_g_v[w1];
        h1 = exp_h_v[w1];
        f3 = stuck_f | exp_f_v[w3];
        g3 = exp_g_v[w3];
        h3 = exp_h_v[w3];
    end

    always_comb begin
        o_w    = sel ? w3    : w1;
        o_tt_f = sel ? ttf3  : ttf1;
        o_tt_g = sel ? ttg3  : ttg1;
        o_tt_h = sel ? tth3  : tth1;
        o_busy = sel ? busy3 : busy1;
        o_done = sel ? done3 : done1;
        o_pass = sel ? pass3 : pass1;
    end

    fgh_truth_scanner #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .f(f1), .g(g1), .h(h1), .w(w1),
        .tt_f(ttf1), .tt_g(ttg1), .tt_h(tth1),
        .busy(busy1), .done(done1), .pass(pass1)
    );

    fgh_truth_scanner #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .f(f3), .g(g3), .h(h3), .w(w3),
        .tt_f(ttf3), .tt_g(ttg3), .tt_h(tth3),
        .busy(busy3), .done(done3), .pass(pass3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on the selected instance; assumes it is idle on entry.
    task automatic sweep(input logic s, input logic [15:0] ef, input logic [15:0] eg,
                         input logic [15:0] eh, input logic ep);
        int settle;
        int lat;
        logic got;
        settle = s ? 3 : 1;
        sel = s;
        lat = 0;
        got = 1'b0;
        if (s) start3 = 1'b1; else start1 = 1'b1;
        step();
        start1 = 1'b0;
        start3 = 1'b0;
        check("busy_at_start", 32'(o_busy), 32'd1);
        check("w_at_start", 32'(o_w), 32'd0);
        check("tables_cleared", 32'(o_tt_f | o_tt_g | o_tt_h), 32'd0);
        for (int k = 1; k <= 16 * settle + 4; k++) begin
            step();
            if (o_done) begin
                lat = k;
                got = 1'b1;
                break;
            end
            check("w_sequence", 32'(o_w), 32'(k / settle));
        end
        check("done_seen", 32'(got), 32'd1);
        check("done_latency", 32'(lat), 32'(16 * settle));
        check("busy_at_done", 32'(o_busy), 32'd0);
        check("w_final", 32'(o_w), 32'd15);
        check("tt_f", 32'(o_tt_f), 32'(ef));
        check("tt_g", 32'(o_tt_g), 32'(eg));
        check("tt_h", 32'(o_tt_h), 32'(eh));
        check("pass_at_done", 32'(o_pass), 32'(ep));
        step();
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("pass_held", 32'(o_pass), 32'(ep));
        check("idle_after_done", 32'(o_busy), 32'd0);
    endtask

    typedef struct {
        logic        s;
        logic        stuck;
        logic [15:0] ef;
        logic [15:0] eg;
        logic [15:0] eh;
        logic        ep;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{s: 1'b0, stuck: 1'b0, ef: 16'h4CC8, eg: 16'h440C, eh: 16'hC08B, ep: 1'b1};
        vecs[1] = '{s: 1'b1, stuck: 1'b0, ef: 16'h4CC8, eg: 16'h440C, eh: 16'hC08B, ep: 1'b1};
        vecs[2] = '{s: 1'b0, stuck: 1'b1, ef: 16'hFFFF, eg: 16'h440C, eh: 16'hC08B, ep: 1'b0};
        vecs[3] = '{s: 1'b1, stuck: 1'b1, ef: 16'hFFFF, eg: 16'h440C, eh: 16'hC08B, ep: 1'b0};

        #12;
        check("rst_w", 32'(w1), 32'd0);
        check("rst_tables", 32'(ttf1 | ttg1 | tth1 | ttf3 | ttg3 | tth3), 32'd0);
        check("rst_flags", 32'({busy1, done1, pass1, busy3, done3, pass3}), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check("idle_no_start", 32'({busy1, busy3}), 32'd0);

        for (int i = 0; i < 4; i++) begin
            stuck_f = vecs[i].stuck;
            sweep(vecs[i].s, vecs[i].ef, vecs[i].eg, vecs[i].eh, vecs[i].ep);
            step();
        end
        stuck_f = 1'b0;

        // Abort while w=5: bits 0..4 stay captured, no done pulse
        begin
            logic reached;
            int   dones;
            reached = 1'b0;
            dones = 0;
            sel = 1'b0;
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (w1 == 4'd5) begin
                    reached = 1'b1;
                    break;
                end
                step();
            end
            check("abort_reach_w5", 32'(reached), 32'd1);
            abort1 = 1'b1;
            step();
            abort1 = 1'b0;
            check("abort_busy", 32'(busy1), 32'd0);
            check("abort_w_held", 32'(w1), 32'd5);
            check("abort_tt_f", 32'(ttf1), 32'h0008);
            check("abort_tt_g", 32'(ttg1), 32'h000C);
            check("abort_tt_h", 32'(tth1), 32'h000B);
            check("abort_pass", 32'(pass1), 32'd0);
            for (int k = 0; k < 20; k++) begin
                if (done1) dones++;
                step();
            end
            check("abort_no_done", 32'(dones), 32'd0);
            check("abort_tables_held", 32'(ttf1), 32'h0008);
        end
        sweep(1'b0, 16'h4CC8, 16'h440C, 16'hC08B, 1'b1);
        step();

        // start held through RUN and DONE, abort alongside start in IDLE: one sweep only
        begin
            int dones;
            int lat;
            dones = 0;
            lat = 0;
            sel = 1'b0;
            start1 = 1'b1;
            abort1 = 1'b1;
            step();
            abort1 = 1'b0;
            check("start_beats_abort", 32'(busy1), 32'd1);
            for (int k = 1; k <= 20; k++) begin
                step();
                if (done1) begin
                    dones++;
                    lat = k;
                    break;
                end
            end
            check("rep_start_latency", 32'(lat), 32'd16);
            step();
            start1 = 1'b0;
            check("rep_start_idle", 32'(busy1), 32'd0);
            for (int k = 0; k < 6; k++) begin
                step();
                if (done1) dones++;
                if (busy1) dones += 100;
            end
            check("rep_start_one_done", 32'(dones), 32'd1);
            check("rep_start_tt_f", 32'(ttf1), 32'h4CC8);
            check("rep_start_pass", 32'(pass1), 32'd1);
        end

        // Asynchronous reset mid-sweep at w=9
        begin
            logic reached;
            reached = 1'b0;
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (w1 == 4'd9) begin
                    reached = 1'b1;
                    break;
                end
                step();
            end
            check("areset_reach_w9", 32'(reached), 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            check("areset_w", 32'(w1), 32'd0);
            check("areset_tables", 32'(ttf1 | ttg1 | tth1), 32'd0);
            check("areset_flags", 32'({busy1, done1, pass1}), 32'd0);
            #3;
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) step();
            check("areset_stays_idle", 32'({busy1, done1, w1}), 32'd0);
        end
        sweep(1'b0, 16'h4CC8, 16'h440C, 16'hC08B, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fgh_truth_scanner.md
# fgh_truth_scanner

Sequential stimulus and capture stage for the 4-input combinational function block (decoder-based outputs f, g, h). On a start request it drives the 4-bit select word w through minterms 0..15 and samples f, g, h into three 16-bit truth-table registers after a programmable settle time. At the end of the sweep it compares the captured tables against expected constants and reports pass/fail with a one-cycle done pulse. It sits directly upstream of the function block: its w output feeds that block, and the block's f/g/h outputs return to this one.

## Interface
- SETTLE, 1: cycles each minterm is held before sampling; legal range 1..15.
- EXP_F, 16'h4CC8: expected f table, bit i = f(w=i).
- EXP_G, 16'h440C: expected g table.
- EXP_H, 16'hC08B: expected h table.

- Clock  in  1  single system clock, rising-edge.
- Resetn  in  1  asynchronous, active-low reset.
- start  in  1  sweep request; sampled only in IDLE.
- abort  in  1  synchronous sweep cancel; effective in RUN only.
- f, g, h  in  1 each  function outputs for the current w.
- w  out  4  minterm index driven to the function block.
- tt_f, tt_g, tt_h  out  16 each  captured truth tables.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at sweep completion.
- pass  out  1  high when all three tables equal their EXP_* values.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: busy=0. On start=1, go to RUN; w<=0; cnt<=SETTLE-1; tt_f/tt_g/tt_h<=0; pass<=0.
- RUN: busy=1. Each cycle:
  - If abort=1, go to IDLE. tt_* keep their partial contents, w is held, pass=0, and done is not pulsed. abort has priority over sampling in the same cycle.
  - Else if cnt==0: write f, g, h into bit index w of tt_f, tt_g, tt_h.
    - If w==15, go to DONE; w stays 15.
    - Otherwise w<=w+1 and cnt<=SETTLE-1.
  - Else cnt<=cnt-1.
- DONE: done=1 for exactly this one cycle. pass<=(tt_f==EXP_F)&&(tt_g==EXP_G)&&(tt_h==EXP_H), using the tables as completed, including the final bit-15 write. Next state is IDLE.
- start is ignored in RUN and DONE; it is neither queued nor restarted. start and abort asserted together in IDLE: start wins, and abort is ignored.
- tt_*, w and pass hold their values in IDLE until the next accepted start.
- cnt width is 4 bits. w increments with no wrap past 15, because the sweep terminates at 15.

## Timing
- Reset (async assert, any state): state=IDLE, w=0, cnt=0, tt_f=tt_g=tt_h=0, busy=0, done=0, pass=0. Reset mid-sweep aborts immediately; nothing is retained.
- start seen high at edge E0: busy=1 and w=0 from E0.
- Minterm i is presented on w for exactly SETTLE cycles. It is sampled at edge E0+(i+1)*SETTLE.
- Last sample is at E0+16*SETTLE. done=1 and pass valid from that edge for one cycle. busy falls at the same edge.
- DONE→IDLE at E0+16*SETTLE+1. The earliest next start is accepted at that edge's following cycle, i.e. start high before edge E0+16*SETTLE+2.
- Sweep latency start→done: 16*SETTLE+1 edges.
- f/g/h must be stable within SETTLE cycles of a w change. The block assumes a combinational function path, so SETTLE=1 suffices.

## Test plan
- Reset, SETTLE=1, connect the real function block, pulse start → w sweeps 0..15 one per cycle; done at cycle 17 after start; tt_f=16'h4CC8, tt_g=16'h440C, tt_h=16'hC08B, pass=1.
- SETTLE=3, same stimulus → each w value held 3 cycles; done at 49 cycles after start; same tables; pass=1.
- Model with f stuck at 1 → tt_f=16'hFFFF, tt_g and tt_h correct, pass=0, done still pulses once.
- Assert abort while w=5 (SETTLE=1) → busy falls next edge, no done pulse; tt_f=16'h0008 (bits 0..4 captured); pass=0. A new start then clears the tables and completes normally.
- Pulse start repeatedly during RUN and in the DONE cycle → exactly one sweep and one done pulse; tables are unchanged by the ignored starts.
- Deassert Resetn asynchronously mid-sweep (w=9) → all outputs zero immediately without a clock edge; after release the block idles until start.
